// File: rtl/ppi_bus_ctrl_if.sv
// ppi_bus_ctrl_if
// CPU-side bus of the 8255A-compatible parallel interface.
// The master modport is the CPU / bus-buffer side: it drives the strobes,
// the register select and the write data. The slave modport is the
// controller, which returns the read data and the buffer drive enable.

interface ppi_bus_ctrl_if;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic [1:0] a;
   logic [7:0] dbus_in;
   logic [7:0] dbus_out;
   logic       dbus_oe;

   modport master (
      output cs_n, rd_n, wr_n, a, dbus_in,
      input  dbus_out, dbus_oe
   );

   modport slave (
      input  cs_n, rd_n, wr_n, a, dbus_in,
      output dbus_out, dbus_oe
   );
endinterface

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl
// Bus-cycle sequencer and register file for an 8255A-compatible parallel
// interface in mode 0. The asynchronous CPU strobes are synchronized and
// decoded into read and write cycles. Port A/B/C output latches, direction
// state and the control word live here.
// Optional feature: define PPI_BSR_EN to make control writes with bit 7 = 0
// perform a port C bit set/reset; without it such writes are ignored.

module ppi_bus_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] RESET_CW    = 8'h9B
) (
   input  logic           clk,
   input  logic           rst,
   ppi_bus_ctrl_if.slave  bus,
   input  logic [7:0]     pa_in_i,
   input  logic [7:0]     pb_in_i,
   input  logic [7:0]     pc_in_i,
   output logic [7:0]     pa_out_o,
   output logic [7:0]     pb_out_o,
   output logic [7:0]     pc_out_o,
   output logic           pa_oe_o,
   output logic           pb_oe_o,
   output logic [7:0]     pc_oe_o,
   output logic           busy_o
);

   localparam int LAST = SYNC_STAGES - 1;

   typedef enum logic [1:0] {IDLE, RD, WR, COMMIT} state_t;

   logic [SYNC_STAGES-1:0] csSync_q;
   logic [SYNC_STAGES-1:0] rdSync_q;
   logic [SYNC_STAGES-1:0] wrSync_q;
   logic [1:0]             aSync_q    [SYNC_STAGES];
   logic [7:0]             dataSync_q [SYNC_STAGES];

   state_t     state_q;
   logic [7:0] cw_q;
   logic [7:0] paOut_q;
   logic [7:0] pbOut_q;
   logic [7:0] pcOut_q;
   logic [7:0] wdata_q;
   logic [1:0] waddr_q;
   logic [7:0] dbusOut_q;
   logic       dbusOe_q;
   logic       busy_q;

   logic       rdAct;
   logic       wrAct;
   logic       rdEnter;
   logic       wrEnter;
   logic [1:0] syncA;
   logic [7:0] syncData;
   logic [7:0] readMux;
   logic       unusedBits;

   // Strobe/address synchronizer plus an equal-depth delay line for the write
   // data, so the data seen by the FSM is the one sampled with the strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         csSync_q <= '1;
         rdSync_q <= '1;
         wrSync_q <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            aSync_q[i]    <= '0;
            dataSync_q[i] <= '0;
         end
      end else begin
         csSync_q      <= {csSync_q[SYNC_STAGES-2:0], bus.cs_n};
         rdSync_q      <= {rdSync_q[SYNC_STAGES-2:0], bus.rd_n};
         wrSync_q      <= {wrSync_q[SYNC_STAGES-2:0], bus.wr_n};
         aSync_q[0]    <= bus.a;
         dataSync_q[0] <= bus.dbus_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            aSync_q[i]    <= aSync_q[i-1];
            dataSync_q[i] <= dataSync_q[i-1];
         end
      end
   end

   // A cycle is only entered once the strobe has been low in the last two
   // synchronizer stages, which filters single-sample glitches without adding
   // latency; staying in a cycle only needs the final stage.
   assign rdAct    = !csSync_q[LAST] && !rdSync_q[LAST];
   assign wrAct    = !csSync_q[LAST] && !wrSync_q[LAST];
   assign rdEnter  = rdAct && !csSync_q[LAST-1] && !rdSync_q[LAST-1];
   assign wrEnter  = wrAct && !csSync_q[LAST-1] && !wrSync_q[LAST-1];
   assign syncA    = aSync_q[LAST];
   assign syncData = dataSync_q[LAST];

   // Read mux: input ports return their pins, output ports their latches;
   // port C decides per nibble and the control address reads as all ones.
   always_comb begin
      readMux = 8'hFF;
      case (syncA)
         2'b00:   readMux = cw_q[4] ? pa_in_i : paOut_q;
         2'b01:   readMux = cw_q[1] ? pb_in_i : pbOut_q;
         2'b10:   readMux = {cw_q[3] ? pc_in_i[7:4] : pcOut_q[7:4],
                             cw_q[0] ? pc_in_i[3:0] : pcOut_q[3:0]};
         default: readMux = 8'hFF;
      endcase
   end

   // Bus-cycle FSM with registered bus outputs and the register file it writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cw_q      <= RESET_CW;
         paOut_q   <= '0;
         pbOut_q   <= '0;
         pcOut_q   <= '0;
         wdata_q   <= '0;
         waddr_q   <= '0;
         dbusOut_q <= '0;
         dbusOe_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rdEnter && !wrAct) begin
                  state_q   <= RD;
                  dbusOut_q <= readMux;
                  dbusOe_q  <= 1'b1;
                  busy_q    <= 1'b1;
               end else if (wrEnter && !rdAct) begin
                  state_q <= WR;
                  waddr_q <= syncA;
                  wdata_q <= syncData;
                  busy_q  <= 1'b1;
               end
            end
            RD: begin
               if (!rdAct || wrAct) begin
                  state_q  <= IDLE;
                  dbusOe_q <= 1'b0;
                  busy_q   <= 1'b0;
               end
            end
            WR: begin
               if (rdAct) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (!wrAct) begin
                  state_q <= COMMIT;
               end else begin
                  wdata_q <= syncData;
               end
            end
            COMMIT: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               case (waddr_q)
                  2'b00: paOut_q <= wdata_q;
                  2'b01: pbOut_q <= wdata_q;
                  2'b10: pcOut_q <= wdata_q;
                  default: begin
                     if (wdata_q[7]) begin
                        cw_q    <= {1'b1, 2'b00, wdata_q[4:3], 1'b0, wdata_q[1:0]};
                        paOut_q <= '0;
                        pbOut_q <= '0;
                        pcOut_q <= '0;
                     end
`ifdef PPI_BSR_EN
                     else begin
                        pcOut_q[wdata_q[3:1]] <= wdata_q[0];
                     end
`endif
                  end
               endcase
            end
            default: begin
               state_q  <= IDLE;
               dbusOe_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign unusedBits   = ^{wdata_q[6:5], wdata_q[2], cw_q[7:5], cw_q[2]};

   assign bus.dbus_out = dbusOut_q;
   assign bus.dbus_oe  = dbusOe_q;
   assign pa_out_o     = paOut_q;
   assign pb_out_o     = pbOut_q;
   assign pc_out_o     = pcOut_q;
   assign pa_oe_o      = ~cw_q[4];
   assign pb_oe_o      = ~cw_q[1];
   assign pc_oe_o      = {{4{~cw_q[3]}}, {4{~cw_q[0]}}};
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// tb_ppi_bus_ctrl
// Self-checking bench for ppi_bus_ctrl (SYNC_STAGES = 2). Bus cycles are
// described as transactions; a register-level model is told, in absolute
// clock-edge numbers, when each read window opens/closes and when each write
// lands, and a compare process checks every output on every cycle.
// Honours PPI_BSR_EN when the design is built with it.

module tb_ppi_bus_ctrl;

   localparam int N = 2;

   localparam int K_RD    = 0;
   localparam int K_WR    = 1;
   localparam int K_CONF  = 2;
   localparam int K_SHORT = 3;

   localparam int EV_RDON   = 0;
   localparam int EV_RDOFF  = 1;
   localparam int EV_WRON   = 2;
   localparam int EV_COMMIT = 3;

   typedef struct {
      int         cyc;
      int         kind;
      logic [1:0] addr;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] paIn = 8'h00;
   logic [7:0] pbIn = 8'h00;
   logic [7:0] pcIn = 8'h00;
   logic [7:0] paOut;
   logic [7:0] pbOut;
   logic [7:0] pcOut;
   logic [7:0] pcOe;
   logic       paOe;
   logic       pbOe;
   logic       busy;

   int         cycle = 0;
   int         nCompared = 0;
   int         nMismatched = 0;
   bit         randPins = 1'b0;
   ev_t        evQ[$];
   int         curKind = K_RD;
   logic [1:0] curAddr = 2'b00;

   // Register-level model of what the outputs must be
   logic [7:0] mCw = 8'h9B;
   logic [7:0] mPa = 8'h00;
   logic [7:0] mPb = 8'h00;
   logic [7:0] mPc = 8'h00;
   logic [7:0] expRd = 8'h00;
   logic       expOe = 1'b0;
   logic       expBusy = 1'b0;

   ppi_bus_ctrl_if busIf();

   ppi_bus_ctrl #(.SYNC_STAGES(N), .RESET_CW(8'h9B)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (busIf),
      .pa_in_i (paIn),
      .pb_in_i (pbIn),
      .pc_in_i (pcIn),
      .pa_out_o(paOut),
      .pb_out_o(pbOut),
      .pc_out_o(pcOut),
      .pa_oe_o (paOe),
      .pb_oe_o (pbOe),
      .pc_oe_o (pcOe),
      .busy_o  (busy)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %02h, expected %02h (cycle %0d)",
                  name, actual, expected, cycle);
      end
   endtask

   task automatic pushEvent(input int cyc, input int kind, input logic [1:0] addr,
                            input logic [7:0] data);
      ev_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      evQ.push_back(e);
   endtask

   function automatic logic [7:0] modelRead(input logic [1:0] addr);
      logic [7:0] v;
      case (addr)
         2'b00:   v = mCw[4] ? paIn : mPa;
         2'b01:   v = mCw[1] ? pbIn : mPb;
         2'b10: begin
            v[7:4] = mCw[3] ? pcIn[7:4] : mPc[7:4];
            v[3:0] = mCw[0] ? pcIn[3:0] : mPc[3:0];
         end
         default: v = 8'hFF;
      endcase
      return v;
   endfunction

   task automatic modelWrite(input logic [1:0] addr, input logic [7:0] data);
      case (addr)
         2'b00: mPa = data;
         2'b01: mPb = data;
         2'b10: mPc = data;
         default: begin
            if (data[7]) begin
               mCw = 8'h80;
               mCw[4] = data[4];
               mCw[3] = data[3];
               mCw[1] = data[1];
               mCw[0] = data[0];
               mPa = 8'h00;
               mPb = 8'h00;
               mPc = 8'h00;
            end else begin
`ifdef PPI_BSR_EN
               mPc[data[3:1]] = data[0];
`endif
            end
         end
      endcase
   endtask

   task automatic modelReset();
      mCw = 8'h9B;
      mPa = 8'h00;
      mPb = 8'h00;
      mPc = 8'h00;
      expOe = 1'b0;
      expBusy = 1'b0;
      expRd = 8'h00;
      evQ.delete();
   endtask

   // Apply the model events due on this edge, then compare all outputs
   initial begin
      forever begin
         @(posedge clk);
         cycle++;
         if (rst) begin
            modelReset();
         end else begin
            ev_t keep[$];
            keep = {};
            foreach (evQ[i]) begin
               if (evQ[i].cyc == cycle) begin
                  case (evQ[i].kind)
                     EV_RDON: begin
                        expRd = modelRead(evQ[i].addr);
                        expOe = 1'b1;
                        expBusy = 1'b1;
                     end
                     EV_RDOFF: begin
                        expOe = 1'b0;
                        expBusy = 1'b0;
                     end
                     EV_WRON: expBusy = 1'b1;
                     default: begin
                        modelWrite(evQ[i].addr, evQ[i].data);
                        expBusy = 1'b0;
                     end
                  endcase
               end else begin
                  keep.push_back(evQ[i]);
               end
            end
            evQ = keep;
         end
         #1;
         checkOutput("dbusOe", {7'b0, busIf.dbus_oe}, {7'b0, expOe});
         checkOutput("busy",   {7'b0, busy}, {7'b0, expBusy});
         checkOutput("paOut",  paOut, mPa);
         checkOutput("pbOut",  pbOut, mPb);
         checkOutput("pcOut",  pcOut, mPc);
         checkOutput("paOe",   {7'b0, paOe}, {7'b0, ~mCw[4]});
         checkOutput("pbOe",   {7'b0, pbOe}, {7'b0, ~mCw[1]});
         checkOutput("pcOe",   pcOe, {{4{~mCw[3]}}, {4{~mCw[0]}}});
         if (expOe) checkOutput("dbusOut", busIf.dbus_out, expRd);
      end
   end

   // Pin inputs wander randomly during the random phase
   initial begin
      forever begin
         @(negedge clk);
         if (randPins) begin
            paIn = 8'($urandom);
            pbIn = 8'($urandom);
            pcIn = 8'($urandom);
         end
      end
   end

   // Start of a bus cycle: strobes go low at a falling edge
   task automatic beginCycle(input int kind, input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      busIf.cs_n    = 1'b0;
      busIf.a       = addr;
      busIf.dbus_in = data;
      if (kind == K_RD || kind == K_CONF) busIf.rd_n = 1'b0;
      if (kind != K_RD) busIf.wr_n = 1'b0;
      curKind = kind;
      curAddr = addr;
      if (kind == K_RD) pushEvent(cycle + 1 + N, EV_RDON, addr, 8'h00);
      if (kind == K_WR) pushEvent(cycle + 1 + N, EV_WRON, addr, 8'h00);
   endtask

   // End of a bus cycle: strobes released, model told when it takes effect
   task automatic endCycle();
      logic [7:0] lastData;
      @(negedge clk);
      lastData = busIf.dbus_in;
      busIf.cs_n = 1'b1;
      busIf.rd_n = 1'b1;
      busIf.wr_n = 1'b1;
      if (curKind == K_RD) pushEvent(cycle + 1 + N, EV_RDOFF, curAddr, 8'h00);
      if (curKind == K_WR) pushEvent(cycle + 2 + N, EV_COMMIT, curAddr, lastData);
   endtask

   // One complete bus cycle; write data wanders until the final low clock
   task automatic applyStimulus(input int kind, input logic [1:0] addr, input logic [7:0] data,
                                input int width, input int gap);
      beginCycle(kind, addr, data);
      for (int i = 1; i < width; i++) begin
         @(negedge clk);
         if (kind == K_WR) busIf.dbus_in = (i == width - 1) ? data : 8'($urandom);
      end
      endCycle();
      repeat (gap) @(negedge clk);
   endtask

   // Read cycle with a literal expectation on the captured data
   task automatic readCheck(input string name, input logic [1:0] addr, input logic [7:0] expected);
      beginCycle(K_RD, addr, 8'h00);
      repeat (N + 1) @(posedge clk);
      #1 checkOutput(name, busIf.dbus_out, expected);
      endCycle();
      repeat (3) @(negedge clk);
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, then randomized traffic
   initial begin
      busIf.cs_n    = 1'b1;
      busIf.rd_n    = 1'b1;
      busIf.wr_n    = 1'b1;
      busIf.a       = 2'b00;
      busIf.dbus_in = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rstBusy", {7'b0, busy}, 8'h00);
      checkOutput("rstOe",   {7'b0, busIf.dbus_oe}, 8'h00);
      checkOutput("rstPaOe", {7'b0, paOe}, 8'h00);
      checkOutput("rstPcOe", pcOe, 8'h00);
      checkOutput("rstPa",   paOut, 8'h00);

      $display("[TB] read port A latency");
      paIn = 8'h5A;
      beginCycle(K_RD, 2'b00, 8'h00);
      repeat (2) @(posedge clk);
      #1 checkOutput("rdOeEarly", {7'b0, busIf.dbus_oe}, 8'h00);
      @(posedge clk);
      #1 checkOutput("rdOeRise", {7'b0, busIf.dbus_oe}, 8'h01);
      checkOutput("rdDataA", busIf.dbus_out, 8'h5A);
      endCycle();
      repeat (2) @(posedge clk);
      #1 checkOutput("rdOeHold", {7'b0, busIf.dbus_oe}, 8'h01);
      @(posedge clk);
      #1 checkOutput("rdOeFall", {7'b0, busIf.dbus_oe}, 8'h00);
      repeat (2) @(negedge clk);

      $display("[TB] mode set and write latency");
      applyStimulus(K_WR, 2'b11, 8'h80, 3, 5);
      checkOutput("msPaOe", {7'b0, paOe}, 8'h01);
      checkOutput("msPbOe", {7'b0, pbOe}, 8'h01);
      checkOutput("msPcOe", pcOe, 8'hFF);
      beginCycle(K_WR, 2'b00, 8'hC3);
      repeat (2) @(negedge clk);
      endCycle();
      repeat (N + 1) @(posedge clk);
      #1 checkOutput("wrPaEarly", paOut, 8'h00);
      @(posedge clk);
      #1 checkOutput("wrPaLatency", paOut, 8'hC3);
      repeat (2) @(negedge clk);
      readCheck("rdBackA", 2'b00, 8'hC3);

      $display("[TB] port C nibble mix");
      applyStimulus(K_WR, 2'b11, 8'h81, 3, 5);
      applyStimulus(K_WR, 2'b10, 8'hA0, 3, 5);
      pcIn = 8'h05;
      readCheck("rdMixC", 2'b10, 8'hA5);

      $display("[TB] bit set/reset");
      applyStimulus(K_WR, 2'b11, 8'h80, 3, 5);
      applyStimulus(K_WR, 2'b11, 8'h0B, 3, 5);
`ifdef PPI_BSR_EN
      checkOutput("bsrPc", pcOut, 8'h20);
`else
      checkOutput("bsrPc", pcOut, 8'h00);
`endif
      checkOutput("bsrPcOe", pcOe, 8'hFF);

      $display("[TB] conflict and short pulse");
      applyStimulus(K_WR, 2'b00, 8'h3C, 3, 5);
      checkOutput("preConfPa", paOut, 8'h3C);
      applyStimulus(K_CONF, 2'b00, 8'h77, 4, 5);
      checkOutput("confPa", paOut, 8'h3C);
      checkOutput("confBusy", {7'b0, busy}, 8'h00);
      applyStimulus(K_SHORT, 2'b00, 8'h55, 1, 5);
      checkOutput("shortPa", paOut, 8'h3C);

      $display("[TB] reset during a write");
      beginCycle(K_WR, 2'b01, 8'h99);
      repeat (2) @(negedge clk);
      @(negedge clk);
      busIf.cs_n = 1'b1;
      busIf.wr_n = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("rstWrPa",   paOut, 8'h00);
      checkOutput("rstWrPb",   pbOut, 8'h00);
      checkOutput("rstWrOe",   {7'b0, busIf.dbus_oe}, 8'h00);
      checkOutput("rstWrBusy", {7'b0, busy}, 8'h00);
      checkOutput("rstWrPcOe", pcOe, 8'h00);

      $display("[TB] random traffic");
      randPins = 1'b1;
      for (int t = 0; t < 150; t++) begin
         int         r;
         int         kind;
         int         width;
         logic [1:0] addr;
         logic [7:0] data;
         r     = int'($urandom_range(0, 99));
         addr  = 2'($urandom);
         data  = 8'($urandom);
         width = int'($urandom_range(N + 1, N + 4));
         if (r < 45)      kind = K_RD;
         else if (r < 90) kind = K_WR;
         else if (r < 95) kind = K_CONF;
         else             kind = K_SHORT;
         if (kind == K_WR && addr == 2'b11 && $urandom_range(0, 1) == 1) data[7] = 1'b1;
         if (kind == K_SHORT) width = 1;
         applyStimulus(kind, addr, data, width, int'($urandom_range(2, 4)));
      end
      randPins = 1'b0;
      repeat (6) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/ppi_bus_ctrl.md
# ppi_bus_ctrl

Bus-cycle sequencer and register file for the 8255A-compatible parallel interface in mode 0. It samples the asynchronous CPU strobes (`cs_n`, `rd_n`, `wr_n`, `a`) and decodes read and write cycles. It drives the direction control and output data of the 8-bit bidirectional bus buffer, and holds the port A/B/C output latches, direction state and control word. It sits between the CPU-side bus buffer and the three port pin buffers.

## Interface
- `SYNC_STAGES`, 2: strobe/address synchronizer depth; legal values 2–3.
- `RESET_CW`, 8'h9B: control word loaded on reset (mode 0, all ports input).
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `cs_n`, `rd_n`, `wr_n`  in  1 each: CPU strobes, asynchronous, active-low.
- `a`  in  2: register select. 00 = A, 01 = B, 10 = C, 11 = control.
- `dbus_in`  in  8: CPU data from the bus buffer.
- `dbus_out`  out  8: read data to the bus buffer.
- `dbus_oe`  out  1: bus buffer drive enable; high = drive the CPU bus.
- `pa_in`, `pb_in`, `pc_in`  in  8 each: port pin inputs.
- `pa_out`, `pb_out`, `pc_out`  out  8 each: port output latches.
- `pa_oe`, `pb_oe`  out  1 each: port A/B drive enable.
- `pc_oe`  out  8: port C per-bit drive enable. [7:4] follow control word bit 3; [3:0] follow bit 0.
- `busy`  out  1: high when the FSM is not in IDLE.

## Operation
- Synchronization:
  - `cs_n`, `rd_n`, `wr_n` and `a` pass through a SYNC_STAGES flop chain.
  - `dbus_in` passes through an equal-depth delay line, so data stays aligned with the strobes.
- Synchronized conditions:
  - rd_act = !cs_n & !rd_n.
  - wr_act = !cs_n & !wr_n.
- FSM states: IDLE, RD, WR, COMMIT.
- IDLE:
  - rd_act & !wr_act → RD. The read value for the synchronized `a` is captured into `dbus_out`.
  - wr_act & !rd_act → WR.
  - Both active → stay in IDLE; the conflict is ignored and nothing is driven.
- RD:
  - `dbus_oe` = 1 and `dbus_out` is held.
  - Exit to IDLE when rd_act drops or wr_act asserts.
- WR:
  - Delayed `dbus_in` is latched into `wdata` every cycle.
  - wr_act drops → COMMIT.
  - rd_act asserts → IDLE with no commit (abort).
- COMMIT: one cycle. Write `wdata` to the register selected by `a`, captured on entry to WR, then → IDLE.
- Read mux:
  - A and B: each port returns its pin input if configured as input, otherwise its output latch.
  - C: per-nibble version of the same rule.
  - Address 11: returns 8'hFF.
- Writes to A, B or C update the output latch regardless of the port's direction.
- Control write with bit 7 = 1 (mode set):
  - Store bit 4 (A input), bit 3 (C upper input), bit 1 (B input) and bit 0 (C lower input).
  - Mode bits 6:5 and 2 are forced to 0.
  - Clear `pa_out`, `pb_out` and `pc_out` to 0.
- Control write with bit 7 = 0: see Configuration.
- Output enables: `pa_oe` = !cw[4], `pb_oe` = !cw[1], `pc_oe` per the Interface entry.

## Timing
- Reset values:
  - FSM = IDLE, `dbus_oe` = 0, `dbus_out` = 0, `busy` = 0.
  - cw = RESET_CW; with the default, all `*_oe` = 0.
  - `pa_out` = `pb_out` = `pc_out` = 0.
  - All synchronizer flops are loaded with their inactive values (strobes high).
- Reset mid-cycle: aborts immediately. `dbus_oe` is low after the reset edge and no pending commit is performed.
- Read assert latency: `dbus_oe` rises SYNC_STAGES+1 rising edges after the first edge that samples `rd_n` low (`cs_n` already low).
- Read release latency: `dbus_oe` falls SYNC_STAGES+1 edges after `rd_n` is sampled high.
- Read data is frozen for the whole of RD; pin changes during RD are not reflected.
- Write latency: the register and port outputs update SYNC_STAGES+2 edges after `wr_n` is sampled high.
- Write data is the last `dbus_in` sampled while `wr_n` was low.
- Minimum strobe low width: SYNC_STAGES+1 clocks. Shorter pulses may be missed; such a pulse produces no action.
- Back-to-back cycles: after COMMIT or a RD exit, IDLE lasts at least one cycle.

## Configuration
- Macro: `PPI_BSR_EN`.
- Defined: a control write with bit 7 = 0 performs a port C bit set/reset. Bit `pc_out[cw[3:1]]` takes the value of bit 0; other bits and the control word are unchanged.
- Undefined: control writes with bit 7 = 0 are ignored entirely.

## Test plan
- Reset then read A with `pa_in` = 8'h5A: `dbus_out` = 8'h5A, `dbus_oe` high 3 edges after `rd_n` falls (SYNC_STAGES = 2), and low 3 edges after `rd_n` rises.
- Write control 8'h80, then write A = 8'hC3:
  - `pa_oe` = `pb_oe` = 1 and `pc_oe` = 8'hFF.
  - `pa_out` = 8'hC3, 4 edges after `wr_n` rises.
  - Read A returns 8'hC3.
- Write control 8'h81 (C lower input), `pc_out` = 8'hA0, `pc_in` = 8'h05: read C returns 8'hA5.
- With `PPI_BSR_EN`, control 8'h80 then BSR 8'h0B: `pc_out[5]` = 1 and the other bits are unchanged. Without the macro, `pc_out` stays 0.
- `rd_n` and `wr_n` low together: `dbus_oe` stays 0 and no register changes. A 1-clock `wr_n` pulse causes no write.
- `rst` asserted mid-write, between WR and the commit edge: no register update, all outputs at their reset values.
